// File: rtl/dc303_dump.sv
// Dump sequencer for the DC303 microcode ROM/PLA. It resets the chip, searches
// for a usable test address, then streams {addr, na, mc} for an address range.
module dc303_dump #(
  parameter logic [4:0] CHIP       = 5'd0,
  parameter logic [9:0] ADDR_FIRST = 10'h080,
  parameter logic [9:0] ADDR_LAST  = 10'h1FF,
  parameter int unsigned HPER      = 1
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  taa,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [9:0]  res_addr,
  output logic [9:0]  res_na,
  output logic [15:0] res_mc,
  output logic        dc_clk,
  output logic        dc_rst,
  output logic        dc_ez_n,
  output logic [15:0] dc_ad,
  output logic [15:0] dc_m_out,
  output logic        dc_m_oe,
  input  logic [15:0] dc_m_in
);

  localparam int unsigned HW = (HPER > 1) ? $clog2(HPER) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HPER - 1);

  localparam logic [15:0] NOP   = 16'hD57F;
  localparam logic [15:0] LD    = 16'hD51F;
  localparam logic [15:0] AXT   = 16'hD50F;
  localparam logic [15:0] DUMMY = 16'h8000;
  localparam logic [15:0] KILL  = 16'h07C0;
  localparam logic [15:0] AD_NU = 16'h0001;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SRCH, S_RD_MC, S_RD_NA, S_OUT, S_DONE
  } state_t;

  typedef struct packed {
    logic        clk;
    logic        rst;
    logic        ez_n;
    logic        m_oe;
    logic [15:0] m_out;
    logic [15:0] ad;
  } bus_t;

  function automatic logic [3:0] last_step(input state_t s);
    case (s)
      S_RST:           last_step = 4'd6;
      S_SRCH, S_RD_MC: last_step = 4'd9;
      S_RD_NA:         last_step = 4'd11;
      default:         last_step = 4'd0;
    endcase
  endfunction

  // Bus values for one script step; IDLE/DONE fall through to the reset image.
  function automatic bus_t script(input state_t s, input logic [3:0] step,
                                  input logic [3:0] sel, input logic [9:0] a);
    bus_t b;
    logic [3:0] lst;
    b.clk   = 1'b0;
    b.rst   = 1'b1;
    b.ez_n  = 1'b0;
    b.m_oe  = 1'b0;
    b.m_out = '0;
    b.ad    = '0;
    lst     = last_step(s);
    case (s)
      S_RST: begin
        b.clk  = ~step[0];
        b.rst  = (step != 4'd6);
        b.ez_n = (step == 4'd6);
      end
      S_SRCH, S_RD_MC, S_RD_NA: begin
        b.clk  = ~step[0];
        b.rst  = 1'b0;
        b.m_oe = 1'b1;
        b.ad   = AD_NU;
        if (step == lst) begin
          b.m_oe = 1'b0;
        end else if (step == lst - 4'd1) begin
          b.ez_n = 1'b1;
          if (s == S_SRCH) begin
            b.m_out = 16'hD17F;
          end else begin
            b.ad    = '0;
            b.m_out = (s == S_RD_MC) ? 16'hD51F : 16'hD11F;
          end
        end else begin
          case (step)
            4'd0: b.m_out = LD;
            4'd1: b.m_out = KILL;
            4'd2: b.m_out = NOP;
            4'd3: b.m_out = (s == S_SRCH) ? {5'b0, CHIP, 2'b11, sel}
                                          : {5'b0, CHIP, ~a[9], 1'b1, sel};
            4'd4: b.m_out = AXT;
            4'd5: b.m_out = (s == S_SRCH) ? {12'h083, sel} : 16'h8030;
            4'd6: begin
              if (s == S_SRCH) begin
                b.m_out = NOP;
              end else begin
                b.m_out = AXT;
                b.ad    = {6'b0, a};
              end
            end
            4'd7: b.m_out = DUMMY;
            4'd8: begin
              b.m_out = LD;
              b.ad    = '0;
            end
            default: b.m_out = DUMMY;
          endcase
        end
      end
      default: ;
    endcase
    return b;
  endfunction

  state_t         st_q, st_d;
  logic [3:0]     step_q, step_d;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [3:0]     i_q, i_d;
  logic [9:0]     a_q, a_d;
  logic [3:0]     taa_q, taa_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           rv_q, rv_d;
  logic [9:0]     raddr_q, raddr_d, rna_q, rna_d;
  logic [15:0]    rmc_q, rmc_d;
  bus_t           bus_q, bus_d;
  logic           load;

  always_comb begin
    st_d    = st_q;
    step_d  = step_q;
    hcnt_d  = hcnt_q;
    i_d     = i_q;
    a_d     = a_q;
    taa_d   = taa_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rv_d    = rv_q;
    raddr_d = raddr_q;
    rna_d   = rna_q;
    rmc_d   = rmc_q;
    load    = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d   = S_RST;
          step_d = '0;
          hcnt_d = '0;
          busy_d = 1'b1;
          err_d  = 1'b0;
          load   = 1'b1;
        end
      end
      S_RST, S_SRCH, S_RD_MC, S_RD_NA: begin
        if (hcnt_q != HLAST) begin
          hcnt_d = hcnt_q + HW'(1);
        end else begin
          hcnt_d = '0;
          load   = 1'b1;
          if (step_q != last_step(st_q)) begin
            step_d = step_q + 4'd1;
          end else begin
            step_d = '0;
            case (st_q)
              S_RST: begin
                st_d = S_SRCH;
                i_d  = 4'd1;
              end
              S_SRCH: begin
                if (dc_m_in[9:0] == 10'h1FF) begin
                  taa_d = i_q;
                  a_d   = ADDR_FIRST;
                  st_d  = S_RD_MC;
                end else if (i_q == 4'd15) begin
                  err_d  = 1'b1;
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  st_d   = S_DONE;
                end else begin
                  i_d = i_q + 4'd1;
                end
              end
              S_RD_MC: begin
                rmc_d = dc_m_in;
                st_d  = S_RD_NA;
              end
              default: begin
                // Bus stays frozen on the last RD_NA step while the result waits.
                rna_d   = dc_m_in[9:0];
                raddr_d = a_q;
                rv_d    = 1'b1;
                load    = 1'b0;
                st_d    = S_OUT;
              end
            endcase
          end
        end
      end
      S_OUT: begin
        if (res_ready) begin
          rv_d   = 1'b0;
          step_d = '0;
          hcnt_d = '0;
          load   = 1'b1;
          if (a_q == ADDR_LAST) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            st_d   = S_DONE;
          end else begin
            a_d  = a_q + 10'd1;
            st_d = S_RD_MC;
          end
        end
      end
      default: begin
        st_d = S_IDLE;
        load = 1'b1;
      end
    endcase
    bus_d = load ? script(st_d, step_d, (st_d == S_SRCH) ? i_d : taa_d, a_d)
                 : bus_q;
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      st_q       <= S_IDLE;
      step_q     <= '0;
      hcnt_q     <= '0;
      i_q        <= '0;
      a_q        <= '0;
      taa_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rv_q       <= 1'b0;
      raddr_q    <= '0;
      rna_q      <= '0;
      rmc_q      <= '0;
      bus_q.clk  <= 1'b0;
      bus_q.rst  <= 1'b1;
      bus_q.ez_n <= 1'b0;
      bus_q.m_oe <= 1'b0;
      bus_q.m_out <= '0;
      bus_q.ad   <= '0;
    end else begin
      st_q    <= st_d;
      step_q  <= step_d;
      hcnt_q  <= hcnt_d;
      i_q     <= i_d;
      a_q     <= a_d;
      taa_q   <= taa_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      raddr_q <= raddr_d;
      rna_q   <= rna_d;
      rmc_q   <= rmc_d;
      bus_q   <= bus_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign taa       = taa_q;
  assign res_valid = rv_q;
  assign res_addr  = raddr_q;
  assign res_na    = rna_q;
  assign res_mc    = rmc_q;
  assign dc_clk    = bus_q.clk;
  assign dc_rst    = bus_q.rst;
  assign dc_ez_n   = bus_q.ez_n;
  assign dc_m_oe   = bus_q.m_oe;
  assign dc_m_out  = bus_q.m_out;
  assign dc_ad     = bus_q.ad;

endmodule

// File: doc/dc303_dump.md
# dc303_dump

Synthesizable dump sequencer sitting directly upstream of the `dc303` microcode ROM/PLA. It drives the chip's clock, reset, AD and M buses to reset the chip and locate a usable test address (TAA). It then reads the next-address field and the microinstruction for every address in a range and streams `{addr, na, mc}` results downstream over a valid/ready handshake. The read sequences are fixed bus scripts; one script step is one DC303 half-period.

## Interface
- `CHIP`, 5'd0 — DC303 chip select code used in jumps
- `ADDR_FIRST`, 10'h080 — first dumped address
- `ADDR_LAST`, 10'h1FF — last dumped address (≥ `ADDR_FIRST`)
- `HPER`, 1 — system clocks per step (≥1)
- `pin_clk` in 1 — system clock; single clock domain
- `pin_rst` in 1 — reset, synchronous, active-high
- `start` in 1 — pulse; starts a dump; ignored while `busy`
- `busy` out 1 — high from start acceptance until done
- `done` out 1 — one-cycle pulse at completion (normal or error)
- `err` out 1 — sticky until next start; set when no TAA is found
- `taa` out 4 — found test address
- `res_valid` out 1, `res_ready` in 1 — result handshake
- `res_addr` out 10, `res_na` out 10, `res_mc` out 16 — result
- `dc_clk` out 1, `dc_rst` out 1, `dc_ez_n` out 1 — to DC303
- `dc_ad` out 16 — DC303 AD bus
- `dc_m_out` out 16, `dc_m_oe` out 1, `dc_m_in` in 16 — DC303 M bus (external tristate)

## Operation
- Constants: NOP=D57F, LD=D51F, AXT=D50F, DUMMY=8000, KILL=07C0 (jump to chip 1F). Default `dc_ad`=0001 (unused PLA address).
- States: IDLE → RST → SRCH → RD_MC → RD_NA → OUT → (RD_MC | DONE) → IDLE.
- IDLE: hold reset values. `start` → RST with `busy`=1.
- RST: 7 steps. `dc_clk`=1,0,1,0,1,0,1; `dc_rst`=1 for the first 6 steps, then 0 with `dc_ez_n`=1. `dc_m_oe`=0, `dc_ad`=0.
- SRCH, test read for i=1..15 (i=0 is never usable). 10 steps; `dc_m_oe`=1 and `dc_ez_n`=0 unless noted; `dc_clk` = 1 on H steps, 0 on L steps.
  - Steps: H LD, L KILL, H NOP, L {5'b0,CHIP,2'b11,i}, H AXT, L 0830|i, H NOP, L DUMMY.
  - Then H D17F with `dc_ez_n`=1, then L with `dc_m_oe`=0.
  - Sample `dc_m_in[9:0]` at the end of the last step. First i giving 1FF → `taa`=i, go to RD_MC with A=`ADDR_FIRST`.
  - No hit after i=15 → `err`=1, DONE.
- RD_MC / RD_NA (address A, `na` flag = 0/1). Common steps:
  - H LD, L KILL, H NOP.
  - L {5'b0,CHIP,2'b11,taa} with bit5=~A[9] and bit4=1.
  - H AXT, L 8030, H AXT with `dc_ad`={6'b0,A}, L DUMMY.
  - RD_NA only: H LD with `dc_ad`=0, then L DUMMY.
  - Final: H with `dc_ad`=0, `dc_ez_n`=1, `dc_m_out`=D51F (RD_MC) or D11F (RD_NA); then L with `dc_m_oe`=0.
  - Sample at the end of the last step: RD_MC → `res_mc`=`dc_m_in`; RD_NA → `res_na`=`dc_m_in[9:0]`.
  - Step count: RD_MC 10, RD_NA 12.
- OUT: `res_valid`=1 with `res_addr`=A. Hold until `res_ready`; all DC303 outputs frozen. On transfer: A==`ADDR_LAST` → DONE, else A+1 → RD_MC.
- DONE: `done` pulse, `busy`=0, `dc_rst`=1, `dc_clk`=0 → IDLE.

## Timing
- All outputs registered; DC303 outputs change at the system edge starting a step and hold for `HPER` clocks.
- Sample taken on the system edge that ends the final step of a script.
- `busy` rises the cycle after `start`. First `res_valid` arrives (7+10·n+22)·`HPER` cycles after start, where n = TAA search attempts.
- `res_valid` rises the cycle after the RD_NA sample and falls the cycle after `res_valid`&`res_ready`.
- Reset values: `dc_clk`=0, `dc_rst`=1, `dc_ez_n`=0, `dc_m_oe`=0, `dc_m_out`=0, `dc_ad`=0. `busy`, `done`, `err`, `res_valid`, `taa`, `res_*` all 0.
- `pin_rst` mid-operation → IDLE next cycle with reset values; no partial result is emitted.
- `start` coincident with `pin_rst` is ignored.

## Test plan
- `start` pulse, HPER=1 → `busy`=1 next cycle; `dc_clk` 1010101 over 7 cycles; `dc_rst` low only on the 7th.
- Stub returns `dc_m_in[9:0]`=1FF only for test reads with i=5 → `taa`=5 after 5 searches. First RD_MC L-step 4 `dc_m_out`=0035; its H-step 7 `dc_ad`=0080.
- Stub never returns 1FF → `err`=1 and `done` pulse after 7+150 steps; `res_valid` never asserts.
- Range 1FE..1FF, stub mc=A5A5, na=0123 → two results (1FE and 1FF) with those values, then `done`. RD_NA final H-step `dc_m_out`=D11F; RD_MC final H-step D51F.
- `res_ready` held low 20 cycles → `res_valid` and all `dc_*` outputs stable; after transfer, `res_addr` increments by 1.
- `pin_rst` during RD_NA → next cycle IDLE, `dc_rst`=1, `busy`=0; a new `start` repeats the TAA search.
